// File: rtl/ej32_rstack.sv
// Return stack for the eJ32 core: cached top-of-stack register over a single-port
// synchronous RAM, with pick/poke, donext, and sticky overflow/underflow flags.
module ej32_rstack #(
    parameter int unsigned DSZ   = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PSZ   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [DSZ-1:0]   d_i,
    input  logic [PSZ-1:0]   idx,
    input  logic             clr,
    output logic [DSZ-1:0]   r_o,
    output logic [DSZ-1:0]   pick_o,
    output logic             pick_vld,
    output logic             taken_o,
    output logic             busy,
    output logic [PSZ:0]     cnt_o,
    output logic             ovf,
    output logic             udf
);

    localparam int unsigned CW = PSZ + 1;
    localparam int unsigned RW = DEPTH - 1;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_MOVE  = 3'd3,
        OP_PICK  = 3'd4,
        OP_POKE  = 3'd5,
        OP_DNEXT = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    logic [DSZ-1:0] r;
    logic [CW-1:0]  cnt;
    logic [DSZ-1:0] pick_q;
    logic           pend_pop;
    logic           pend_pick;

    logic [DSZ-1:0] mem [RW];
    logic [DSZ-1:0] ram_q;
    logic           ram_we;
    logic           ram_re;
    logic [PSZ-1:0] ram_addr;
    logic [DSZ-1:0] ram_wd;

    op_e            op_c;
    logic           accept_c;
    logic           full_c;
    logic           empty_c;
    logic           idx_ok_c;
    logic           idx_zero_c;
    logic           deep_c;
    logic           do_pop_c;
    logic           set_ovf_c;
    logic           set_udf_c;

    assign op_c       = op_e'(op);
    assign accept_c   = en & ~busy;
    assign full_c     = (cnt == CW'(DEPTH));
    assign empty_c    = (cnt == '0);
    assign idx_ok_c   = ({1'b0, idx} < cnt);
    assign idx_zero_c = (idx == '0);
    assign deep_c     = (cnt >= CW'(2));
    // DNEXT on a zero counter degenerates into a plain pop
    assign do_pop_c   = (op_c == OP_POP) || ((op_c == OP_DNEXT) && !empty_c && (r == '0));

    // RAM port control and error detection for the accepted op
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wd    = r;
        set_ovf_c = 1'b0;
        set_udf_c = 1'b0;
        if (accept_c) begin
            case (op_c)
                OP_PUSH: begin
                    if (full_c) begin
                        set_ovf_c = 1'b1;
                    end else if (!empty_c) begin
                        ram_we   = 1'b1;
                        ram_addr = PSZ'(cnt - CW'(1));
                    end
                end
                OP_POP, OP_DNEXT: begin
                    if (empty_c) begin
                        set_udf_c = 1'b1;
                    end else if (do_pop_c && deep_c) begin
                        ram_re   = 1'b1;
                        ram_addr = PSZ'(cnt - CW'(2));
                    end
                end
                OP_PICK, OP_POKE: begin
                    if (!idx_ok_c) begin
                        set_udf_c = 1'b1;
                    end else if (!idx_zero_c) begin
                        ram_we   = (op_c == OP_POKE);
                        ram_re   = (op_c == OP_PICK);
                        ram_addr = PSZ'(cnt - CW'(1) - {1'b0, idx});
                        ram_wd   = d_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single-port storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wd;
        end else if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            cnt       <= '0;
            pick_q    <= '0;
            pend_pop  <= 1'b0;
            pend_pick <= 1'b0;
            pick_vld  <= 1'b0;
            taken_o   <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            pick_vld <= 1'b0;
            taken_o  <= 1'b0;
            ovf      <= (ovf & ~clr) | set_ovf_c;
            udf      <= (udf & ~clr) | set_udf_c;
            if (busy) begin
                busy      <= 1'b0;
                pend_pop  <= 1'b0;
                pend_pick <= 1'b0;
                if (pend_pop)  r      <= ram_q;
                if (pend_pick) pick_q <= ram_q;
            end else if (accept_c) begin
                case (op_c)
                    OP_PUSH: begin
                        if (!full_c) begin
                            r   <= d_i;
                            cnt <= cnt + CW'(1);
                        end
                    end
                    OP_MOVE: r <= d_i;
                    OP_POP, OP_DNEXT: begin
                        if (!empty_c) begin
                            if (!do_pop_c) begin
                                r       <= r - DSZ'(1);
                                taken_o <= 1'b1;
                            end else if (deep_c) begin
                                cnt      <= cnt - CW'(1);
                                busy     <= 1'b1;
                                pend_pop <= 1'b1;
                            end else begin
                                r   <= '0;
                                cnt <= '0;
                            end
                        end
                    end
                    OP_PICK: begin
                        busy     <= 1'b1;
                        pick_vld <= 1'b1;
                        if (!idx_ok_c)       pick_q    <= '0;
                        else if (idx_zero_c) pick_q    <= r;
                        else                 pend_pick <= 1'b1;
                    end
                    OP_POKE: begin
                        if (idx_ok_c && idx_zero_c) r <= d_i;
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM read data is steered straight out during the pick busy cycle, then held
    assign pick_o = pend_pick ? ram_q : pick_q;
    assign r_o    = r;
    assign cnt_o  = cnt;

endmodule

// File: tb/tb_ej32_rstack.sv
// Directed self-checking bench for ej32_rstack (DEPTH reduced to 16).
module tb_ej32_rstack;

    localparam int unsigned DSZ   = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PSZ   = 4;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, MOVE = 3'd3,
                           PICK = 3'd4, POKE = 3'd5, DNEXT = 3'd6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [2:0]     op = 3'd0;
    logic [DSZ-1:0] d_i = '0;
    logic [PSZ-1:0] idx = '0;
    logic           clr = 1'b0;
    logic [DSZ-1:0] r_o;
    logic [DSZ-1:0] pick_o;
    logic           pick_vld;
    logic           taken_o;
    logic           busy;
    logic [PSZ:0]   cnt_o;
    logic           ovf;
    logic           udf;

    int vecs = 0;
    int errs = 0;

    ej32_rstack #(.DSZ(DSZ), .DEPTH(DEPTH), .PSZ(PSZ)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .d_i(d_i), .idx(idx), .clr(clr),
        .r_o(r_o), .pick_o(pick_o), .pick_vld(pick_vld), .taken_o(taken_o),
        .busy(busy), .cnt_o(cnt_o), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [DSZ-1:0] d, input logic [PSZ-1:0] i);
        en = 1'b1; op = o; d_i = d; idx = i;
        tick();
        en = 1'b0; op = NOP;
    endtask

    task automatic do_reset();
        en = 1'b0; clr = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if ({r_o, pick_o, pick_vld, taken_o, busy, cnt_o, ovf, udf} !== '0) begin
            errs++;
            $display("FAIL reset: r=%h pick=%h vld=%b tk=%b busy=%b cnt=%0d ovf=%b udf=%b, all expected 0",
                     r_o, pick_o, pick_vld, taken_o, busy, cnt_o, ovf, udf);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            issue(PUSH, 32'(32'h100 + i), '0);
            vecs++;
            if (cnt_o !== 5'(i) || r_o !== 32'(32'h100 + i) || busy !== 1'b0) begin
                errs++;
                $display("FAIL push_%0d: cnt=%0d r=%h busy=%b, expected cnt=%0d r=%h busy=0",
                         i, cnt_o, r_o, busy, i, 32'h100 + i);
            end
        end
        issue(PUSH, 32'hDEAD, '0);
        vecs++;
        if (ovf !== 1'b1 || cnt_o !== 5'(DEPTH) || r_o !== 32'h110) begin
            errs++;
            $display("FAIL push_full: ovf=%b cnt=%0d r=%h, expected ovf=1 cnt=16 r=00000110", ovf, cnt_o, r_o);
        end
        for (int c = DEPTH; c >= 1; c--) begin
            issue(POP, '0, '0);
            if (c >= 2) begin
                vecs++;
                if (busy !== 1'b1 || cnt_o !== 5'(c - 1)) begin
                    errs++;
                    $display("FAIL pop_accept_%0d: busy=%b cnt=%0d, expected busy=1 cnt=%0d", c, busy, cnt_o, c - 1);
                end
                tick();
                vecs++;
                if (busy !== 1'b0 || r_o !== 32'(32'h100 + c - 1)) begin
                    errs++;
                    $display("FAIL pop_data_%0d: busy=%b r=%h, expected busy=0 r=%h", c, busy, r_o, 32'h100 + c - 1);
                end
            end else begin
                vecs++;
                if (busy !== 1'b0 || cnt_o !== 5'd0 || r_o !== 32'd0 || ovf !== 1'b1 || udf !== 1'b0) begin
                    errs++;
                    $display("FAIL pop_last: busy=%b cnt=%0d r=%h ovf=%b udf=%b, expected 0 0 0 1 0",
                             busy, cnt_o, r_o, ovf, udf);
                end
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(POP, '0, '0);
        vecs++;
        if (udf !== 1'b1 || cnt_o !== 5'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL pop_empty: udf=%b cnt=%0d busy=%b, expected udf=1 cnt=0 busy=0", udf, cnt_o, busy);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        vecs++;
        if (udf !== 1'b0) begin
            errs++;
            $display("FAIL clr: udf=%b, expected 0", udf);
        end
        clr = 1'b1; issue(POP, '0, '0); clr = 1'b0;
        vecs++;
        if (udf !== 1'b1) begin
            errs++;
            $display("FAIL clr_vs_set: udf=%b, expected 1", udf);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        issue(DNEXT, '0, '0);
        vecs++;
        if (udf !== 1'b1 || taken_o !== 1'b0 || cnt_o !== 5'd0) begin
            errs++;
            $display("FAIL dnext_empty: udf=%b taken=%b cnt=%0d, expected 1 0 0", udf, taken_o, cnt_o);
        end
        issue(MOVE, 32'h55, '0);
        vecs++;
        if (r_o !== 32'h55 || cnt_o !== 5'd0) begin
            errs++;
            $display("FAIL move_empty: r=%h cnt=%0d, expected r=00000055 cnt=0", r_o, cnt_o);
        end
    endtask

    task automatic test_pick_poke();
        do_reset();
        issue(PUSH, 32'd10, '0);
        issue(PUSH, 32'd20, '0);
        issue(PUSH, 32'd30, '0);
        issue(PICK, '0, 4'd2);
        vecs++;
        if (pick_vld !== 1'b1 || busy !== 1'b1 || pick_o !== 32'd10) begin
            errs++;
            $display("FAIL pick2: vld=%b busy=%b pick=%0d, expected 1 1 10", pick_vld, busy, pick_o);
        end
        tick();
        vecs++;
        if (pick_vld !== 1'b0 || busy !== 1'b0 || pick_o !== 32'd10) begin
            errs++;
            $display("FAIL pick2_hold: vld=%b busy=%b pick=%0d, expected 0 0 10", pick_vld, busy, pick_o);
        end
        issue(POKE, 32'd99, 4'd1);
        vecs++;
        if (busy !== 1'b0 || r_o !== 32'd30 || cnt_o !== 5'd3) begin
            errs++;
            $display("FAIL poke1: busy=%b r=%0d cnt=%0d, expected 0 30 3", busy, r_o, cnt_o);
        end
        issue(PICK, '0, 4'd1);
        vecs++;
        if (pick_vld !== 1'b1 || pick_o !== 32'd99) begin
            errs++;
            $display("FAIL pick1: vld=%b pick=%0d, expected 1 99", pick_vld, pick_o);
        end
        tick();
        issue(POKE, 32'd77, 4'd0);
        issue(PICK, '0, 4'd0);
        vecs++;
        if (pick_vld !== 1'b1 || pick_o !== 32'd77 || r_o !== 32'd77) begin
            errs++;
            $display("FAIL pick0: vld=%b pick=%0d r=%0d, expected 1 77 77", pick_vld, pick_o, r_o);
        end
        tick();
        issue(PICK, '0, 4'd3);
        vecs++;
        if (udf !== 1'b1 || pick_o !== 32'd0 || pick_vld !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL pick3: udf=%b pick=%0d vld=%b busy=%b, expected 1 0 1 1", udf, pick_o, pick_vld, busy);
        end
        tick();
    endtask

    task automatic test_dnext();
        do_reset();
        issue(PUSH, 32'd5, '0);
        issue(PUSH, 32'd2, '0);
        issue(DNEXT, '0, '0);
        vecs++;
        if (taken_o !== 1'b1 || r_o !== 32'd1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL dnext1: taken=%b r=%0d busy=%b, expected 1 1 0", taken_o, r_o, busy);
        end
        issue(DNEXT, '0, '0);
        vecs++;
        if (taken_o !== 1'b1 || r_o !== 32'd0) begin
            errs++;
            $display("FAIL dnext2: taken=%b r=%0d, expected 1 0", taken_o, r_o);
        end
        issue(DNEXT, '0, '0);
        vecs++;
        if (taken_o !== 1'b0 || busy !== 1'b1 || cnt_o !== 5'd1) begin
            errs++;
            $display("FAIL dnext3: taken=%b busy=%b cnt=%0d, expected 0 1 1", taken_o, busy, cnt_o);
        end
        tick();
        vecs++;
        if (busy !== 1'b0 || r_o !== 32'd5 || taken_o !== 1'b0 || udf !== 1'b0) begin
            errs++;
            $display("FAIL dnext3_data: busy=%b r=%0d taken=%b udf=%b, expected 0 5 0 0", busy, r_o, taken_o, udf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(PUSH, 32'd1, '0);
        issue(PUSH, 32'd2, '0);
        issue(PUSH, 32'd3, '0);
        en = 1'b1; op = POP;
        tick();
        op = PUSH; d_i = 32'd7;
        tick();
        vecs++;
        if (cnt_o !== 5'd2 || r_o !== 32'd2 || busy !== 1'b0) begin
            errs++;
            $display("FAIL push_while_busy: cnt=%0d r=%0d busy=%b, expected 2 2 0", cnt_o, r_o, busy);
        end
        tick();
        en = 1'b0; op = NOP;
        vecs++;
        if (cnt_o !== 5'd3 || r_o !== 32'd7) begin
            errs++;
            $display("FAIL push_retry: cnt=%0d r=%0d, expected 3 7", cnt_o, r_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(PUSH, 32'd1, '0);
        issue(PUSH, 32'd2, '0);
        issue(PICK, '0, 4'd1);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({r_o, pick_o, pick_vld, taken_o, busy, cnt_o, ovf, udf} !== '0) begin
            errs++;
            $display("FAIL reset_mid: r=%h pick=%h vld=%b tk=%b busy=%b cnt=%0d, all expected 0",
                     r_o, pick_o, pick_vld, taken_o, busy, cnt_o);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if (pick_vld !== 1'b0 || pick_o !== 32'd0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL reset_release_%0d: vld=%b pick=%h busy=%b, expected 0 0 0", k, pick_vld, pick_o, busy);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_fill_drain();
        test_underflow();
        test_pick_poke();
        test_dnext();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
